dmem_responder: RTL

Data-memory responder serving the pipeline's Memory stage. Accepts one word-wide load or store per request, models a fixed multi-cycle access latency, and returns read data with a one-cycle ready pulse. Drives a stall signal to the hazard unit so that the Fetch, Decode and Execute stages hold while an access is outstanding.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: FSM state encoding,
// latency counter width and default geometry/latency.
// ---------------------------------------------------------------------------
package dmem_pkg;

    // Responder FSM: accept in IDLE, count down in WAIT, complete in DONE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    // Wide enough for LATENCY-2 with LATENCY up to 15.
    localparam int unsigned CNT_W = 4;

    localparam int unsigned DEFAULT_LATENCY = 2;
    localparam int unsigned DEFAULT_DEPTH   = 64;

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x 32-bit word storage with one synchronous write port and one
// combinational read port. The parent registers the read result.
//
// Ports:
//   clk_i      clock; writes happen on the rising edge
//   we_i       write enable
//   windex_i   word index for the write
//   wdata_i    write data
//   rindex_i   word index for the combinational read
//   rdata_o    read data (combinational from rindex_i)
// ---------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] windex_i,
    input  logic [31:0]              wdata_i,
    input  logic [$clog2(DEPTH)-1:0] rindex_i,
    output logic [31:0]              rdata_o
);

    // No reset: contents survive a responder reset.
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[windex_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rindex_i];

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the Memory stage. Accepts one word load or store
// per request, holds it for a fixed LATENCY, then pulses MemReadyM for one
// cycle with registered ReadData / MemErrM. MemStallM holds the upstream
// pipeline while an access is outstanding.
//
// Ports:
//   clk         clock
//   reset       asynchronous active-low reset (memory contents kept)
//   MemReqM     access request, held by the requester through DONE
//   MemWriteM   1 = store, 0 = load (sampled at acceptance)
//   ALUOutM     byte address (sampled at acceptance)
//   WriteDataM  store data (sampled at acceptance)
//   ReadData    load result, registered, valid with MemReadyM
//   MemReadyM   one-cycle completion pulse
//   MemErrM     misaligned-access flag, valid with MemReadyM
//   MemStallM   MemReqM & ~MemReadyM
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    output logic        MemReadyM,
    output logic        MemErrM,
    output logic        MemStallM
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    // Only the word index and byte offset of the address are kept.
    localparam int unsigned AW    = IDX_W + 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH < 4 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH must be a power of two in 4..4096");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             write_q, write_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    // -----------------------------------------------------------------------
    // Access selection
    // With LATENCY=1 the access completes on the acceptance edge, so the live
    // inputs must drive the read and the alignment check while in IDLE.
    // -----------------------------------------------------------------------
    logic [AW-1:0]    acc_addr;
    logic             acc_write;
    logic             acc_misaligned;
    logic [IDX_W-1:0] rindex;
    logic [31:0]      arr_rdata;
    logic             complete;

    assign acc_addr       = (state_q == ST_IDLE) ? ALUOutM[AW-1:0] : addr_q;
    assign acc_write      = (state_q == ST_IDLE) ? MemWriteM : write_q;
    assign acc_misaligned = (acc_addr[1:0] != 2'b00);
    assign rindex         = acc_addr[AW-1:2];

    // Upper address bits wrap by design.
    logic unused_addr;
    assign unused_addr = ^ALUOutM[31:AW];

    // -----------------------------------------------------------------------
    // Storage. The store commits on the edge that ends DONE, which is never
    // the same edge as the next acceptance.
    // -----------------------------------------------------------------------
    logic arr_we;
    assign arr_we = (state_q == ST_DONE) && write_q && (addr_q[1:0] == 2'b00);

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i    (clk),
        .we_i     (arr_we),
        .windex_i (addr_q[AW-1:2]),
        .wdata_i  (wdata_q),
        .rindex_i (rindex),
        .rdata_o  (arr_rdata)
    );

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        complete = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (MemReqM) begin
                    addr_d  = ALUOutM[AW-1:0];
                    wdata_d = WriteDataM;
                    write_d = MemWriteM;
                    if (LATENCY == 1) begin
                        state_d  = ST_DONE;
                        complete = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = ST_DONE;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Result registers update only on DONE entry and hold until the next.
        if (complete) begin
            err_d   = acc_misaligned;
            rdata_d = (acc_write || acc_misaligned) ? 32'h0 : arr_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ReadData  = rdata_q;
    assign MemErrM   = err_q;
    assign MemReadyM = (state_q == ST_DONE);
    assign MemStallM = MemReqM & ~MemReadyM;

endmodule
